// File: rtl/ntsc_sync_sep.sv
// ntsc_sync_sep: composite-sync separator recovering NTSC line/field timing from a 4fsc SYNC stream.
// Optional build macro NTSC_SEP_GLITCH_FILT_EN adds a 3-tap majority filter on SYNC_i (HD latency 2 -> 4).
module ntsc_sync_sep #(
    parameter int P_H_SIZE  = 910,
    parameter int P_H_TOL   = 8,
    parameter int P_EQU_MAX = 50,
    parameter int P_HS_MAX  = 120,
    parameter int P_V_LOAD  = 3,
    parameter int P_LOCK_N  = 8,
    parameter int P_MISS_N  = 4
) (
    input  logic       CK_i,
    input  logic       R_i,
    input  logic       CK_EE_i,
    input  logic       SYNC_i,
    output logic       XHD_o,
    output logic       XVD_o,
    output logic       FI_o,
    output logic [9:0] H_CTR_o,
    output logic [8:0] V_CTR_o,
    output logic       LOCK_o
);
    localparam logic [9:0] H_LAST   = 10'(P_H_SIZE - 1);
    localparam logic [9:0] H_LATE   = 10'(P_H_SIZE - 1 - P_H_TOL);
    localparam logic [9:0] H_EARLY  = 10'(P_H_TOL - 1);
    localparam logic [9:0] H_MID_LO = 10'(P_H_SIZE / 2 - 1 - P_H_TOL);
    localparam logic [9:0] H_MID_HI = 10'(P_H_SIZE / 2 - 1 + P_H_TOL);
    localparam logic [8:0] W_EQU    = 9'(P_EQU_MAX);
    localparam logic [8:0] W_HS     = 9'(P_HS_MAX);
    localparam logic [8:0] V_LOAD   = 9'(P_V_LOAD);
    localparam logic [3:0] LOCK_N   = 4'(P_LOCK_N);
    localparam logic [3:0] MISS_N   = 4'(P_MISS_N);

    typedef enum logic [1:0] {CLS_EQU, CLS_HS, CLS_BROAD} pulse_cls_t;

    function automatic logic [8:0] inc_sat9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    function automatic logic [3:0] inc_sat_lock(input logic [3:0] v);
        return (v >= LOCK_N) ? v : v + 4'd1;
    endfunction

    logic sync_in;

`ifdef NTSC_SEP_GLITCH_FILT_EN
    logic [1:0] sync_sr;
    logic       sync_maj;

    always_ff @(posedge CK_i) begin
        if (R_i) begin
            sync_sr  <= 2'b11;
            sync_maj <= 1'b1;
        end else if (CK_EE_i) begin
            sync_sr  <= {sync_sr[0], SYNC_i};
            sync_maj <= (SYNC_i & sync_sr[0]) | (sync_sr[0] & sync_sr[1]) | (SYNC_i & sync_sr[1]);
        end
    end

    assign sync_in = sync_maj;
`else
    assign sync_in = SYNC_i;
`endif

    logic       sync_d;
    logic       seen_hi;
    logic [8:0] lw;
    logic       tag_line;
    logic       tag_mid;
    logic       fe_line_p1;
    logic       fe_win_p1;
    logic       broad_seen;
    logic       vs_pend;
    logic       vs_fi;
    logic [3:0] hit;
    logic [3:0] miss;

    logic       fe;
    logic       re;
    logic       in_win;
    logic       in_mid;
    logic       line_start;
    logic [3:0] hit_inc;
    logic [3:0] miss_inc;
    pulse_cls_t cls;

    // seen_hi keeps a pulse already in progress at reset release from posing as a falling edge
    assign fe         = seen_hi & sync_d & ~sync_in;
    assign re         = ~sync_d & sync_in;
    assign in_win     = (H_CTR_o >= H_LATE) || (H_CTR_o <= H_EARLY);
    assign in_mid     = (H_CTR_o >= H_MID_LO) && (H_CTR_o <= H_MID_HI);
    assign line_start = fe_line_p1 || (H_CTR_o == H_LAST);
    assign hit_inc    = inc_sat_lock(hit);
    assign miss_inc   = miss + 4'd1;

    always_comb begin
        cls = CLS_EQU;
        if (lw >= W_HS) begin
            cls = CLS_BROAD;
        end else if (lw >= W_EQU) begin
            cls = CLS_HS;
        end
    end

    always_ff @(posedge CK_i) begin
        if (R_i) begin
            sync_d     <= 1'b1;
            seen_hi    <= 1'b0;
            lw         <= 9'd0;
            tag_line   <= 1'b0;
            tag_mid    <= 1'b0;
            fe_line_p1 <= 1'b0;
            fe_win_p1  <= 1'b0;
            broad_seen <= 1'b0;
            vs_pend    <= 1'b0;
            vs_fi      <= 1'b0;
            hit        <= 4'd0;
            miss       <= 4'd0;
            XHD_o      <= 1'b1;
            XVD_o      <= 1'b1;
            FI_o       <= 1'b0;
            H_CTR_o    <= 10'd0;
            V_CTR_o    <= 9'd0;
            LOCK_o     <= 1'b0;
        end else if (CK_EE_i) begin
            // stage 0: edge detect, width measurement, FE tagging
            sync_d <= sync_in;
            if (sync_in) begin
                seen_hi <= 1'b1;
            end
            if (fe) begin
                lw <= 9'd0;
            end else if (!sync_in) begin
                lw <= inc_sat9(lw);
            end
            fe_line_p1 <= fe && (!LOCK_o || in_win);
            fe_win_p1  <= fe && in_win;
            if (fe) begin
                tag_line <= !LOCK_o || in_win;
                tag_mid  <= LOCK_o && !in_win && in_mid;
            end
            if (re) begin
                if (cls == CLS_BROAD) begin
                    if (!broad_seen && (tag_line || tag_mid)) begin
                        vs_pend <= 1'b1;
                        vs_fi   <= tag_mid;
                    end
                    broad_seen <= 1'b1;
                end else begin
                    broad_seen <= 1'b0;
                end
            end

            // stage 1: line start, vertical load, lock bookkeeping
            XHD_o <= !line_start;
            XVD_o <= !(line_start && vs_pend);
            if (line_start) begin
                H_CTR_o <= 10'd0;
                if (vs_pend) begin
                    V_CTR_o <= V_LOAD;
                    FI_o    <= vs_fi;
                    vs_pend <= 1'b0;
                end else begin
                    V_CTR_o <= inc_sat9(V_CTR_o);
                end
                if (fe_line_p1) begin
                    if (fe_win_p1) begin
                        hit  <= hit_inc;
                        miss <= 4'd0;
                        if (hit_inc == LOCK_N) begin
                            LOCK_o <= 1'b1;
                        end
                    end
                end else begin
                    hit <= 4'd0;
                    if (miss_inc == MISS_N) begin
                        LOCK_o <= 1'b0;
                        miss   <= 4'd0;
                    end else begin
                        miss <= miss_inc;
                    end
                end
            end else begin
                H_CTR_o <= H_CTR_o + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_ntsc_sync_sep.sv
// Scoreboard bench for ntsc_sync_sep: pulse-level reference model predicts every line start.
module tb_ntsc_sync_sep;
    localparam int H = 910;
`ifdef NTSC_SEP_GLITCH_FILT_EN
    localparam int XDLY = 2;
    localparam bit FILT = 1'b1;
`else
    localparam int XDLY = 0;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       sync;
    logic       xhd;
    logic       xvd;
    logic       fi;
    logic       lock;
    logic [9:0] hctr;
    logic [8:0] vctr;

    ntsc_sync_sep dut (
        .CK_i    (clk),
        .R_i     (rst),
        .CK_EE_i (ce),
        .SYNC_i  (sync),
        .XHD_o   (xhd),
        .XVD_o   (xvd),
        .FI_o    (fi),
        .H_CTR_o (hctr),
        .V_CTR_o (vctr),
        .LOCK_o  (lock)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int at;
        bit lk;
        int v;
        bit fi;
        bit vd;
    } exp_t;

    exp_t q[$];

    // Reference model state: edge of last line start, lock bookkeeping, vertical state.
    int m_last;
    bit m_lock;
    int m_hit;
    int m_miss;
    int m_v;
    bit m_fi;
    bit m_prev_broad;
    bit m_pend;
    bit m_pend_fi;
    int m_pend_edge;

    task automatic emit(input int e);
        exp_t x;
        bit vd;
        vd = 1'b0;
        if (m_pend && e > m_pend_edge) begin
            m_v    = 3;
            m_fi   = m_pend_fi;
            m_pend = 1'b0;
            vd     = 1'b1;
        end else if (m_v < 511) begin
            m_v++;
        end
        x = '{e, m_lock, m_v, m_fi, vd};
        q.push_back(x);
        m_last = e;
    endtask

    task automatic flywheel_to(input int upto);
        while (m_last + H <= upto) begin
            m_hit = 0;
            m_miss++;
            if (m_miss == 4) begin
                m_lock = 1'b0;
                m_miss = 0;
            end
            emit(m_last + H);
        end
    endtask

    task automatic model_pulse(input int t, input int w);
        int te;
        int h;
        bit win;
        bit line;
        bit mid_tag;
        bit broad;
        if (FILT && w < 2) return;
        te = t + XDLY;
        flywheel_to(te);
        h       = te - 1 - m_last;
        win     = (h >= H - 1 - 8) || (h <= 7);
        line    = !m_lock || win;
        mid_tag = m_lock && !win && (h >= 446) && (h <= 462);
        if (line) begin
            if (win) begin
                m_miss = 0;
                if (m_hit < 8) m_hit++;
                if (m_hit == 8) m_lock = 1'b1;
            end
            emit(te + 1);
        end
        broad = (w - 1) >= 120;
        if (broad && !m_prev_broad && (line || mid_tag)) begin
            m_pend      = 1'b1;
            m_pend_fi   = mid_tag;
            m_pend_edge = te + w;
        end
        m_prev_broad = broad;
        flywheel_to(te + w);
    endtask

    // FE at edge t means SYNC_i is first sampled low at posedge number t.
    task automatic send(input int t, input int w);
        model_pulse(t, w);
        while (cyc < t - 1) @(negedge clk);
        sync = 1'b0;
        while (cyc < t + w - 1) @(negedge clk);
        sync = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && !xhd) begin
                if (q.size() == 0) begin
                    check("unexpected_hd_strobe", cyc, -1);
                end else begin
                    x = q.pop_front();
                    check("hd_cycle", cyc, x.at);
                    check("hctr_at_hd", int'(hctr), 0);
                    check("lock_at_hd", int'(lock), int'(x.lk));
                    check("vctr_at_hd", int'(vctr), x.v);
                    check("fi_at_hd", int'(fi), int'(x.fi));
                    check("vd_at_hd", int'(!xvd), int'(x.vd));
                end
            end else if (!rst && !xvd) begin
                check("vd_without_hd", int'(xvd), 1);
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: cycle budget expired at cycle %0d, expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int last;
        int b;
        int s;
        rst  = 1'b1;
        ce   = 1'b1;
        sync = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_xhd", int'(xhd), 1);
        check("rst_xvd", int'(xvd), 1);
        check("rst_fi", int'(fi), 0);
        check("rst_hctr", int'(hctr), 0);
        check("rst_vctr", int'(vctr), 0);
        check("rst_lock", int'(lock), 0);

        m_last = cyc;
        m_lock = 1'b0;
        m_hit = 0;
        m_miss = 0;
        m_v = 0;
        m_fi = 1'b0;
        m_prev_broad = 1'b0;
        m_pend = 1'b0;
        m_pend_fi = 1'b0;
        m_pend_edge = 0;
        rst = 1'b0;

        // acquisition: 20 hsyncs with small early jitter
        last = cyc + 60;
        send(last, int'($urandom_range(80, 60)));
        for (int i = 1; i < 20; i++) begin
            last = last + H - int'($urandom_range(6, 0));
            send(last, int'($urandom_range(80, 60)));
        end

        // four missing hsyncs, then reacquire
        last = last + 5 * H - int'($urandom_range(6, 0));
        send(last, int'($urandom_range(80, 60)));
        for (int i = 0; i < 9; i++) begin
            last = last + H - int'($urandom_range(6, 0));
            send(last, int'($urandom_range(80, 60)));
        end

        // field 0: vsync starts on a line edge
        b = last + H;
        for (int i = 0; i < 18; i++) begin
            send(b + 455 * i, (i >= 6 && i < 12) ? 388 : 36);
        end
        last = b + 455 * 16;
        for (int i = 0; i < 3; i++) begin
            last = last + H - int'($urandom_range(6, 0));
            send(last, int'($urandom_range(80, 60)));
        end

        // field 1: vsync starts at half line
        b = last + 455;
        for (int i = 0; i < 18; i++) begin
            send(b + 455 * i, (i >= 6 && i < 12) ? 388 : 36);
        end
        last = b + 455 * 17;
        for (int i = 0; i < 2; i++) begin
            last = last + H - int'($urandom_range(6, 0));
            send(last, int'($urandom_range(80, 60)));
        end

        // stray pulse and 1-clock glitch mid-line while locked
        send(last + 302, 20);
        send(last + 502, 1);
        for (int i = 0; i < 3; i++) begin
            last = last + H - int'($urandom_range(6, 0));
            send(last, int'($urandom_range(80, 60)));
        end

        // freeze mid-line with clock enable low, then reset while disabled
        s = last + 400;
        flywheel_to(s);
        while (cyc < s) @(negedge clk);
        ce = 1'b0;
        repeat (100) @(negedge clk);
        check("frz_hctr", int'(hctr), s - m_last);
        check("frz_lock", int'(lock), int'(m_lock));
        check("frz_vctr", int'(vctr), m_v);
        check("frz_fi", int'(fi), int'(m_fi));
        check("frz_xhd", int'(xhd), 1);
        check("frz_xvd", int'(xvd), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_xhd", int'(xhd), 1);
        check("rst2_xvd", int'(xvd), 1);
        check("rst2_fi", int'(fi), 0);
        check("rst2_hctr", int'(hctr), 0);
        check("rst2_vctr", int'(vctr), 0);
        check("rst2_lock", int'(lock), 0);
        check("pending_hd_strobes", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
